serial_operand_feeder: RTL
==========================

# serial_operand_feeder

Parallel-to-serial front end for the serial adder with valid. It accepts a pair of W-bit operands through a valid/ready handshake and emits them LSB-first, one bit pair per cycle, on a vld/a/b/last stream that connects directly to the adder's inputs. A pause input inserts bubbles into the stream without losing or reordering bits.

## Interface
- W, default 8: operand width in bits; legal range is W >= 1.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_vld  in  1  in_a/in_b hold a valid operand pair.
- in_rdy  out  1  feeder can accept a pair this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- pause  in  1  suppress bit emission this cycle; state holds.
- out_vld  out  1  out_a/out_b/out_last are valid this cycle.
- out_a  out  1  current bit of A.
- out_b  out  1  current bit of B.
- out_last  out  1  current bit is the MSB (final bit) of the word.

## Operation
- State: busy flag, W-bit shift registers sa and sb, bit counter cnt of width max(1, $clog2(W)).
- IDLE (busy=0):
  - in_rdy=1.
  - On in_vld at the edge: sa<=in_a, sb<=in_b, cnt<=0, busy<=1.
- SHIFT (busy=1):
  - out_vld = !pause.
  - out_a = sa[0], out_b = sb[0].
  - out_last = out_vld && (cnt == W-1).
  - At an edge with out_vld=1: sa and sb shift right by one, cnt increments.
  - If out_last=1 at that edge: busy<=0 and sa/sb are cleared, unless a preload occurs (see Configuration).
  - At an edge with pause=1: nothing changes.
- out_last is never high while out_vld is low. This is required: the downstream adder clears its carry on last regardless of vld.
- While idle, out_a, out_b, out_last and out_vld are all 0. pause has no effect while idle.
- W=1: every emitted bit has out_last=1.
- No downstream backpressure. Once a bit is presented without pause, it is consumed at the next edge.

## Timing
- Reset values: in_rdy=1, out_vld=0, out_a=0, out_b=0, out_last=0, busy=0, cnt=0.
- Reset asserted mid-word aborts the word; no partial last is emitted. in_rdy=1 from the first cycle after release.
- Latency:
  - A pair accepted at edge k presents bit 0 in the cycle after edge k.
  - With no pauses, bit W-1 is presented in cycle k+W, which ends the word.
- Each paused cycle extends the word by exactly one cycle.
- outs are combinational from registers and pause. in_rdy is registered state only, unless the macro below is enabled.
- Without the macro, throughput is W+1 cycles per word: there is one idle cycle between words, and out_vld=0 in that cycle.

## Configuration
- Macro: SERIAL_OPERAND_FEEDER_PRELOAD_EN.
- Defined:
  - in_rdy = !busy || out_last.
  - A pair accepted at the edge that consumes the last bit loads directly into sa/sb; cnt<=0 and busy stays 1.
  - Words stream back-to-back with zero gap, at W cycles per word.
  - in_rdy becomes combinational from pause.
- Undefined: in_rdy = !busy, and the one-cycle inter-word gap applies.

## Test plan
- Basic word: W=4, in_a=4'b0110, in_b=4'b0011, no pause.
  - out_a = 0,1,1,0 and out_b = 1,1,0,0 over 4 consecutive cycles.
  - out_last high on the 4th cycle only.
  - in_rdy low for those 4 cycles.
- Pause mid-word: same pair, pause=1 during the 2nd emitted bit.
  - That cycle shows out_vld=0 and out_last=0.
  - The bit sequence is unchanged and total duration is 5 cycles.
  - A pause on the final bit delays out_last by one cycle.
- Back-to-back: present 4'hF/4'h1 followed by 4'h0/4'h0 with in_vld held high.
  - Without the macro: exactly one out_vld=0 cycle between the words.
  - With the macro: 8 consecutive valid cycles, with out_last on cycles 4 and 8.
- Reset mid-word: assert rst after 2 bits of a W=4 word.
  - All outputs go to 0 immediately (asynchronously).
  - No out_last is seen, and in_rdy=1 after release.
- End-to-end, W=8: feed the adder with 8'd200 + 8'd100.
  - Collected sum bits equal 8'd44 (mod 256).
  - A following 8'd1 + 8'd1 yields 8'd2, which confirms the carry was cleared by out_last.
- W=1 corner: a stream of pairs 1/1, 0/1.
  - Every valid cycle has out_last=1.
  - Adder outputs are 0 then 1.

Source files
------------

// File: rtl/serial_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_operand_feeder
// Brief    : Accepts a W-bit operand pair over valid/ready and streams it
//            LSB-first as vld/a/b/last bit pairs for a serial adder.
//            Optional macro SERIAL_OPERAND_FEEDER_PRELOAD_EN enables
//            back-to-back words by loading the next pair on the last bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_operand_feeder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         pause,
  output logic         out_vld,
  output logic         out_a,
  output logic         out_b,
  output logic         out_last
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out_a    = 1'b0;
    out_b    = 1'b0;
    out_last = 1'b0;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_rdy = 1'b1;
        load   = in_vld;
      end
      ST_SHIFT: begin
        out_vld  = !pause;
        out_a    = sa_q[0];
        out_b    = sb_q[0];
        // Gated by !pause: the adder clears its carry on last even without vld
        out_last = !pause && (cnt_q == LAST_CNT);
        if (out_vld) begin
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
        if (out_last) begin
          state_d = ST_IDLE;
          sa_d    = '0;
          sb_d    = '0;
          cnt_d   = '0;
`ifdef SERIAL_OPERAND_FEEDER_PRELOAD_EN
          in_rdy  = 1'b1;
          load    = in_vld;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      sa_d    = in_a;
      sb_d    = in_b;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end
  end

endmodule
`default_nettype wire
